srl_fifo: RTL and testbench

- Shift-register FIFO built on an addressable SRL-style storage chain; the write side shifts words in at tap 0, the read side selects the oldest word by tap address.
- Sits directly downstream of the fixed-depth shift chains in the Xilinx SRL flow.
- Adds valid/ready handshakes and occupancy tracking so a variable-occupancy buffer still maps onto SRL primitives.
- Storage carries no reset and no init, so synth_xilinx maps it to SRLs; only control state resets.

---
 rtl/srl_fifo_pkg.sv | 12 +
 rtl/srl_tap_chain.sv | 20 ++
 rtl/srl_fifo.sv | 47 ++++
 tb/tb_srl_fifo.sv | 120 ++++++++++++
 4 files changed

// File: rtl/srl_fifo_pkg.sv
// srl_fifo_pkg: width helpers shared by the SRL FIFO files
package srl_fifo_pkg;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int count_width(input int depth);
      return clog2(depth + 1);
   endfunction
endpackage

// File: rtl/srl_tap_chain.sv
// srl_tap_chain: reset-free shift array with tap mux, shaped for SRL inference
module srl_tap_chain import srl_fifo_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] sr [DEPTH];
   always_ff @(posedge clk)
      if (ce) begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   assign q = sr[addr];
endmodule

// File: rtl/srl_fifo.sv
// srl_fifo: valid/ready FIFO whose oldest word is read by tap address from an SRL chain
module srl_fifo import srl_fifo_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AFULL = DEPTH - 2,
   localparam int CW = count_width(DEPTH),
   localparam int AW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             almost_full
);
   logic          push, pop;
   logic [AW-1:0] addr;
   assign wr_ready    = count != CW'(DEPTH);
   assign rd_valid    = count != '0;
   assign almost_full = count >= CW'(AFULL);
   assign push        = wr_valid & wr_ready & ~flush;
   assign pop         = rd_valid & rd_ready & ~flush;
   assign addr        = rd_valid ? AW'(count - 1'b1) : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (flush) count <= '0;
      else if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
   // push+pop leaves addr fixed: the shift itself slides the next-oldest word under the tap
   srl_tap_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chain (
      .clk  (clk),
      .ce   (push),
      .d    (wr_data),
      .addr (addr),
      .q    (rd_data)
   );
   a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !wr_ready && !pop && !flush |=> count == CW'(DEPTH));
   a_rd_stable: assert property (@(posedge clk) disable iff (!rst_n)
      rd_valid && !rd_ready && !push && !flush |=> $stable(rd_data));
endmodule

// File: tb/tb_srl_fifo.sv
// tb_srl_fifo: directed checks of srl_fifo with hand-computed expectations
module tb_srl_fifo;
   logic       clk = 0, rst_n = 0, flush = 0, wr_valid = 0, rd_ready = 0;
   logic       wr_ready, rd_valid, almost_full;
   logic [7:0] wr_data = '0, rd_data;
   logic [4:0] count;
   int         checks = 0, passes = 0;
   logic [7:0] exp_q [5];

   srl_fifo #(.WIDTH(8), .DEPTH(16), .AFULL(14)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .count(count), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs == exp) passes++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      wr_valid = 1;
      wr_data  = d;
      tick();
      wr_valid = 0;
   endtask

   task automatic pop_word(input logic [7:0] exp, input string tag);
      check(tag, rd_data, exp);
      rd_ready = 1;
      tick();
      rd_ready = 0;
   endtask

   initial begin
      #12;
      check("rst_count", count, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_afull", almost_full, 0);
      rst_n = 1;
      tick();
      push_word(8'hA1);
      push_word(8'hB2);
      push_word(8'hC3);
      check("t1_count", count, 3);
      check("t1_rd_data", rd_data, 8'hA1);
      check("t1_rd_valid", rd_valid, 1);
      check("t1_wr_ready", wr_ready, 1);
      pop_word(8'hA1, "t2_d0");
      check("t2_c0", count, 2);
      pop_word(8'hB2, "t2_d1");
      check("t2_c1", count, 1);
      pop_word(8'hC3, "t2_d2");
      check("t2_c2", count, 0);
      check("t2_rd_valid", rd_valid, 0);
      for (int i = 0; i < 16; i++) begin
         push_word(8'(i));
         check("t3_afull", almost_full, (i + 1) >= 14);
      end
      check("t3_count", count, 16);
      check("t3_wr_ready", wr_ready, 0);
      push_word(8'hFF);
      check("t3_drop_count", count, 16);
      for (int i = 0; i < 16; i++) pop_word(8'(i), "t3_drain");
      check("t3_empty", count, 0);
      for (int i = 0; i < 5; i++) push_word(8'(8'h10 + i));
      check("t4_count5", count, 5);
      for (int i = 0; i < 4; i++) begin
         check("t4_head", rd_data, 8'h10 + i);
         wr_valid = 1;
         wr_data  = 8'(8'h55 + i);
         rd_ready = 1;
         tick();
         check("t4_count", count, 5);
      end
      wr_valid = 0;
      rd_ready = 0;
      exp_q = '{8'h14, 8'h55, 8'h56, 8'h57, 8'h58};
      for (int i = 0; i < 5; i++) pop_word(exp_q[i], "t4_order");
      check("t4_empty", count, 0);
      for (int i = 0; i < 7; i++) push_word(8'(8'h70 + i));
      check("t5_count7", count, 7);
      flush    = 1;
      wr_valid = 1;
      wr_data  = 8'h77;
      tick();
      flush    = 0;
      wr_valid = 0;
      check("t5_count", count, 0);
      check("t5_rd_valid", rd_valid, 0);
      push_word(8'h99);
      check("t5_after", rd_data, 8'h99);
      check("t5_after_count", count, 1);
      pop_word(8'h99, "t5_pop");
      for (int i = 0; i < 9; i++) push_word(8'(8'h20 + i));
      check("t6_count9", count, 9);
      #3 rst_n = 0;
      #1;
      check("t6_count", count, 0);
      check("t6_rd_valid", rd_valid, 0);
      check("t6_wr_ready", wr_ready, 1);
      #2 rst_n = 1;
      tick();
      push_word(8'h3C);
      check("t6_data", rd_data, 8'h3C);
      check("t6_after_count", count, 1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
